// File: rtl/wave_pkg.sv
// Shared constants and the quarter-wave sine table generator for the waveform LUT stage.
package wave_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    localparam int unsigned ROM_DEPTH = 512;
    localparam int unsigned ROM_AW    = 9;
    localparam int unsigned ROM_DW    = 15;
    localparam int          FULL_POS  = 32767;

    // pi in unsigned Q60 fixed point
    localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

    // round(32767 * sin(2*pi*(k+0.5)/2048)), evaluated with a Q60 Taylor series
    function automatic logic [ROM_DW-1:0] sine_entry(input int unsigned k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        x    = (128'(PI_Q60) * 128'(2 * k + 1)) >> 11;
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if ((n % 2) == 1) sum = sum - term;
            else              sum = sum + term;
        end
        return ROM_DW'((sum * 128'(FULL_POS) + (128'(1) << 59)) >> 60);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// 512 x 15 quarter-wave sine ROM with a registered (1-clk) read port.
// ROM_FILE names the equivalent hex image; contents are computed at elaboration.
module quarter_sine_rom
    import wave_pkg::*;
#(
    parameter string ROM_FILE = "quarter_sine.hex"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] addr,
    output logic [ROM_DW-1:0] data
);

    logic [ROM_DW-1:0] rom_mem [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic [ROM_DW-1:0] Entry = sine_entry(k);
        assign rom_mem[k] = Entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else begin
            data <= rom_mem[addr];
        end
    end

endmodule

// File: rtl/wave_lut_gen.sv
// Waveform synthesis stage: phase address -> sine/square/triangle/saw, amplitude scaled,
// five-clock pipeline from the s_clk strobe to a one-clock dout_vld pulse.
module wave_lut_gen
    import wave_pkg::*;
#(
    parameter string ROM_FILE = "quarter_sine.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_clk,
    input  logic        en,
    input  logic [10:0] addr,
    input  logic [1:0]  wave_sel,
    input  logic [7:0]  amp,
    output logic [15:0] dout,
    output logic        dout_vld
);

    logic pl0, pl1, strobe, strobe_d, en_d;

    // stage 1: captured inputs and folded sine index
    logic              s1_vld;
    logic [10:0]       addr_q;
    logic [1:0]        sel1_q;
    logic [7:0]        amp1_q;
    logic [ROM_AW-1:0] idx_q;
    logic              neg1_q;

    // stage 2: ROM data plus arithmetic waveforms
    logic              s2_vld;
    logic [ROM_DW-1:0] rom_data;
    logic [15:0]       sq_q, tri_q, saw_q;
    logic [1:0]        sel2_q;
    logic [7:0]        amp2_q;
    logic              neg2_q;

    // stage 3: selected waveform value
    logic              s3_vld;
    logic signed [15:0] w_q;
    logic [7:0]        amp3_q;

    logic [15:0]        sq_w, tri_w, saw_w, sine_w, w_sel;
    logic signed [24:0] prod;
    logic [15:0]        scaled;

    assign strobe = pl0 & ~pl1;

    quarter_sine_rom #(
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (idx_q),
        .data (rom_data)
    );

    always_comb begin
        sq_w   = addr_q[10] ? 16'(-FULL_POS) : 16'(FULL_POS);
        tri_w  = addr_q[10] ? 16'h7fff - {addr_q[9:0], 6'b0}
                            : {addr_q[9:0], 6'b0} - 16'h8000;
        saw_w  = {~addr_q[10], addr_q[9:0], 5'b0};
        sine_w = neg2_q ? 16'd0 - {1'b0, rom_data} : {1'b0, rom_data};
        w_sel  = sine_w;
        unique case (wave_e'(sel2_q))
            WAVE_SINE:   w_sel = sine_w;
            WAVE_SQUARE: w_sel = sq_q;
            WAVE_TRI:    w_sel = tri_q;
            WAVE_SAW:    w_sel = saw_q;
        endcase
        // amp is zero-extended so the multiply stays signed; floor shift cannot overflow
        prod   = w_q * $signed({1'b0, amp3_q});
        scaled = 16'(prod >>> 8);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pl0      <= 1'b0;
            pl1      <= 1'b0;
            strobe_d <= 1'b0;
            en_d     <= 1'b0;
            s1_vld   <= 1'b0;
            addr_q   <= '0;
            sel1_q   <= '0;
            amp1_q   <= '0;
            idx_q    <= '0;
            neg1_q   <= 1'b0;
            s2_vld   <= 1'b0;
            sq_q     <= '0;
            tri_q    <= '0;
            saw_q    <= '0;
            sel2_q   <= '0;
            amp2_q   <= '0;
            neg2_q   <= 1'b0;
            s3_vld   <= 1'b0;
            w_q      <= '0;
            amp3_q   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            pl0      <= s_clk;
            pl1      <= pl0;
            strobe_d <= strobe;
            en_d     <= en;

            // upstream addr has already moved to the new phase one cycle after the strobe
            s1_vld <= strobe_d & en_d;
            if (strobe_d) begin
                addr_q <= addr;
                sel1_q <= wave_sel;
                amp1_q <= amp;
                idx_q  <= addr[9] ? ~addr[8:0] : addr[8:0];
                neg1_q <= addr[10];
            end

            s2_vld <= s1_vld;
            sq_q   <= sq_w;
            tri_q  <= tri_w;
            saw_q  <= saw_w;
            sel2_q <= sel1_q;
            amp2_q <= amp1_q;
            neg2_q <= neg1_q;

            s3_vld <= s2_vld;
            w_q    <= w_sel;
            amp3_q <= amp2_q;

            dout_vld <= s3_vld;
            if (s3_vld) begin
                dout <= scaled;
            end
        end
    end

endmodule
